// File: rtl/chan_mux_rr_pkg.sv
// ---------------------------------------------------------------------------
// chan_mux_pkg
// Shared definitions for the channel multiplexer:
//   mode_e : selection mode encoding carried on the 1-bit mode input
//            MODE_MANUAL (0) - channel chosen by the external sel input
//            MODE_RR     (1) - channel chosen by the round-robin arbiter
// ---------------------------------------------------------------------------
package chan_mux_pkg;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_RR     = 1'b1
   } mode_e;

endpackage : chan_mux_pkg

// File: rtl/chan_mux_rr_if.sv
// ---------------------------------------------------------------------------
// chan_mux_rr_if
// Bus bundle between the channel sources/sink and chan_mux_rr.
//   in_data   N*W  channel i occupies bits [i*W +: W]
//   in_valid  N    per-channel data valid
//   in_ready  N    per-channel accept strobe (one-hot or zero)
//   mode      1    0 = manual select, 1 = round-robin
//   sel       SW   channel select, used in manual mode only
//   out_data  W    registered selected word
//   out_ch    SW   index of the channel that supplied out_data
//   out_valid 1    out_data/out_ch hold a word
//   out_ready 1    downstream accepts when out_valid & out_ready
// master = traffic side (sources + sink), slave = the multiplexer.
// ---------------------------------------------------------------------------
interface chan_mux_rr_if #(
   parameter int W = 8,
   parameter int N = 4
);
   localparam int SW = $clog2(N);

   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic           mode;
   logic [SW-1:0]  sel;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_ch;
   logic           out_valid;
   logic           out_ready;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_ch, out_valid
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_ch, out_valid
   );

endinterface : chan_mux_rr_if

// File: rtl/chan_mux_rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin candidate search with a rotating priority pointer.
//   clk           clock, rising edge
//   rst_n         synchronous active-low reset (pointer returns to 0)
//   req_i         N   request vector (channel valids)
//   advance_i     1   a grant was consumed this cycle; rotate pointer
//   grant_o       SW  first requesting channel at or above ptr, wrapping
//   grant_valid_o 1   at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req_i,
   input  logic          advance_i,
   output logic [SW-1:0] grant_o,
   output logic          grant_valid_o
);

   logic [SW-1:0] ptr_q;
   logic [SW-1:0] ptr_d;

   // Walk offsets from highest to lowest so the final hit is the request
   // closest to ptr in the wrapped search order.
   always_comb begin
      int idx;
      idx           = 0;
      grant_o       = '0;
      grant_valid_o = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         if (req_i[idx]) begin
            grant_o       = SW'(idx);
            grant_valid_o = 1'b1;
         end
      end
   end

   assign ptr_d = (int'(grant_o) == N - 1) ? '0 : grant_o + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (advance_i && grant_valid_o) begin
         ptr_q <= ptr_d;
      end
   end

endmodule : rr_arbiter

// File: rtl/chan_mux_rr.sv
// ---------------------------------------------------------------------------
// chan_mux_rr
// N-channel to one multiplexer with a single registered output stage.
// The candidate channel comes from sel (manual mode) or from the
// round-robin arbiter (RR mode). The candidate's in_ready is raised only
// when the output register can load; a transfer lands in the output
// register one cycle later. Load and drain in the same cycle keep full
// throughput.
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset; clears output word and pointer
//   bus    chan_mux_rr_if.slave (see interface header for signal list)
// ---------------------------------------------------------------------------
module chan_mux_rr
   import chan_mux_pkg::*;
#(
   parameter  int W  = 8,
   parameter  int N  = 4,
   localparam int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   chan_mux_rr_if.slave  bus
);

   logic [W-1:0]  out_data_q;
   logic [SW-1:0] out_ch_q;
   logic          out_valid_q;

   logic          can_load;
   logic [SW-1:0] cand;
   logic          cand_vld;
   logic [W-1:0]  cand_data;
   logic [N-1:0]  ready_d;
   logic          xfer;
   logic          rr_mode;

   logic [SW-1:0] arb_grant;
   logic          arb_grant_vld;

   assign rr_mode  = (bus.mode == MODE_RR);
   assign can_load = ~out_valid_q | bus.out_ready;

   rr_arbiter #(.N(N)) u_arb (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_i         (bus.in_valid),
      .advance_i     (rr_mode & xfer),
      .grant_o       (arb_grant),
      .grant_valid_o (arb_grant_vld)
   );

   // Manual select never looks at in_valid, so in_ready stays independent
   // of it; an out-of-range sel simply has no candidate.
   always_comb begin
      cand     = bus.sel;
      cand_vld = (int'(bus.sel) < N);
      if (rr_mode) begin
         cand     = arb_grant;
         cand_vld = arb_grant_vld;
      end
   end

   always_comb begin
      ready_d   = '0;
      cand_data = '0;
      for (int i = 0; i < N; i++) begin
         if (cand == SW'(i)) begin
            cand_data  = bus.in_data[i*W +: W];
            ready_d[i] = cand_vld & can_load & rst_n;
         end
      end
   end

   assign xfer = |(bus.in_valid & ready_d);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
      end else if (can_load) begin
         out_valid_q <= xfer;
         if (xfer) begin
            out_data_q <= cand_data;
            out_ch_q   <= cand;
         end
      end
   end

   assign bus.in_ready  = ready_d;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_valid = out_valid_q;

endmodule : chan_mux_rr

// File: tb/tb_chan_mux_rr.sv
// ---------------------------------------------------------------------------
// tb_chan_mux_rr
// Directed, table-driven bench for chan_mux_rr (W=8, N=4). Each table row
// is one clock cycle: inputs are applied, in_ready is compared before the
// edge, and the output register is compared after it. Rows are cumulative,
// so arbiter pointer history carries from row to row.
// Channel words: ch0=3C, ch1=11, ch2=A5, ch3=D4.
// ---------------------------------------------------------------------------
module tb_chan_mux_rr;

   localparam int W = 8;
   localparam int N = 4;

   logic clk;
   logic rst_n;

   chan_mux_rr_if #(.W(W), .N(N)) bus ();

   chan_mux_rr #(.W(W), .N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic       mode;
      logic [1:0] sel;
      logic [3:0] vld;
      logic       ordy;
      logic [3:0] exp_rdy;
      logic       exp_ov;
      logic [7:0] exp_od;
      logic [1:0] exp_ch;
   } vec_t;

   localparam int NV = 21;
   vec_t vt [NV];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic m, input logic [1:0] s,
                               input logic [3:0] v, input logic o, input logic [3:0] er,
                               input logic eov, input logic [7:0] eod, input logic [1:0] ech);
      vec_t t;
      t.rst_n = r;  t.mode = m;     t.sel = s;     t.vld = v;      t.ordy = o;
      t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_ch = ech;
      return t;
   endfunction

   // One cycle: drive, check in_ready, clock, check output register.
   task automatic step(input string tag, input logic r, input logic m, input logic [1:0] s,
                       input logic [3:0] v, input logic o, input logic [3:0] er,
                       input logic eov, input logic [7:0] eod, input logic [1:0] ech);
      rst_n         = r;
      bus.mode      = m;
      bus.sel       = s;
      bus.in_valid  = v;
      bus.out_ready = o;
      #1;
      chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(er));
      @(posedge clk);
      #1;
      chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(eov));
      chk({tag, " out_data"}, 32'(bus.out_data), 32'(eod));
      chk({tag, " out_ch"}, 32'(bus.out_ch), 32'(ech));
   endtask

   initial begin
      bus.in_data   = 32'hD4A5_113C;
      bus.in_valid  = '0;
      bus.mode      = 1'b1;
      bus.sel       = '0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;

      //           rst  mode sel    valid    ordy  exp_rdy  ov    od     ch
      // reset held with all channels valid
      vt[0]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
      vt[1]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
      // release: RR from ptr 0, then fairness 0,1,2,3,0
      vt[2]  = mk(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h3C, 2'd0);
      vt[3]  = mk(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
      vt[4]  = mk(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
      vt[5]  = mk(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hD4, 2'd3);
      vt[6]  = mk(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h3C, 2'd0);
      // ptr=1: take ch2 -> ptr=3; skip to ch1 -> ptr=2; 1001 -> ch3, ptr wraps to 0
      vt[7]  = mk(1'b1, 1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
      vt[8]  = mk(1'b1, 1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
      vt[9]  = mk(1'b1, 1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'hD4, 2'd3);
      vt[10] = mk(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h3C, 2'd0);
      // manual: sel=2 loads A5; sel=3 with ch3 idle -> ready anyway, output empties
      vt[11] = mk(1'b1, 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
      vt[12] = mk(1'b1, 1'b0, 2'd3, 4'b0000, 1'b1, 4'b1000, 1'b0, 8'hA5, 2'd2);
      // back to RR: manual cycles left ptr at 1
      vt[13] = mk(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
      // backpressure: load 3C, hold two cycles, then drain + load ch1 together
      vt[14] = mk(1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h3C, 2'd0);
      vt[15] = mk(1'b1, 1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0);
      vt[16] = mk(1'b1, 1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0);
      vt[17] = mk(1'b1, 1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
      // mid-stream reset with a held word (RR ptr was 2)
      vt[18] = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0);
      vt[19] = mk(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h3C, 2'd0);
      vt[20] = mk(1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h3C, 2'd0);

      for (int i = 0; i < NV; i++) begin
         step($sformatf("vec%0d", i), vt[i].rst_n, vt[i].mode, vt[i].sel, vt[i].vld,
              vt[i].ordy, vt[i].exp_rdy, vt[i].exp_ov, vt[i].exp_od, vt[i].exp_ch);
      end

      // RR load into an empty register while downstream stalls: ptr=1 -> ch1.
      step("rr_stall_load", 1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0010, 1'b1, 8'h11, 2'd1);
      // Stalled cycles must neither change the word nor rotate the pointer.
      for (int c = 0; c < 3; c++) begin
         step($sformatf("rr_stall%0d", c), 1'b1, 1'b1, 2'd0, 4'b1111, 1'b0,
              4'b0000, 1'b1, 8'h11, 2'd1);
      end
      // Release: pointer moved exactly once (to 2).
      step("rr_release", 1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
      // Changing data mid-stream: new ch3 word appears on the next grant.
      bus.in_data[3*W +: W] = 8'h7E;
      step("rr_newdata", 1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h7E, 2'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_chan_mux_rr

// File: doc/chan_mux_rr.md
CHAN_MUX_RR -- requirements
Module: chan_mux_rr

Interface
REQ-001 The module SHALL have parameter W, default 8, giving data width per channel in bits.
REQ-002 The module SHALL have parameter N, default 4, giving input channel count (legal range 2..16).
REQ-003 The module SHALL have derived localparam SW = $clog2(N), giving channel-index width.
REQ-004 Port clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 Port rst_n SHALL be: input, 1 bit, synchronous active-low reset.
REQ-006 Port in_data SHALL be: input, N*W bits, channel i occupies bits [i*W +: W].
REQ-007 Port in_valid SHALL be: input, N bits, per-channel data-valid.
REQ-008 Port in_ready SHALL be: output, N bits, per-channel accept strobe.
REQ-009 Port mode SHALL be: input, 1 bit, 0 = MANUAL (external select), 1 = RR (round-robin).
REQ-010 Port sel SHALL be: input, SW bits, channel select used in MANUAL mode only.
REQ-011 Port out_data SHALL be: output, W bits, registered selected data.
REQ-012 Port out_ch SHALL be: output, SW bits, index of the channel that supplied out_data.
REQ-013 Port out_valid SHALL be: output, 1 bit, out_data/out_ch hold a word.
REQ-014 Port out_ready SHALL be: input, 1 bit, downstream accepts the word when out_valid & out_ready.

Function
REQ-015 Output stage SHALL be a single register; can_load = ~out_valid | out_ready.
REQ-016 MANUAL: candidate = sel; if sel >= N, no candidate and all in_ready = 0.
REQ-017 RR: candidate = first i with in_valid[i]=1, searching from ptr upward with wrap at N-1 -> 0; none if in_valid = 0.
REQ-018 in_ready[i] SHALL be 1 only for i = candidate and only when can_load; all other bits 0 (one-hot or zero).
REQ-019 in_ready SHALL be independent of in_valid in MANUAL mode, and depend on in_valid only through candidate search in RR.
REQ-020 Transfer occurs when in_valid[c] & in_ready[c]; next cycle out_data = in_data channel c, out_ch = c, out_valid = 1 (latency 1 cycle).
REQ-021 If can_load and no transfer, out_valid SHALL go to 0 at the next edge; if ~can_load, out_data/out_ch/out_valid SHALL hold.
REQ-022 Simultaneous drain and load SHALL sustain one word per cycle with no bubble.
REQ-023 ptr SHALL update to (c+1) mod N only on an RR-mode transfer; unchanged otherwise, including in MANUAL mode.
REQ-024 Mode or sel changes SHALL take effect combinationally on the current cycle's candidate; a held output word is unaffected.
REQ-025 No input word SHALL be lost or duplicated; each handshake yields exactly one output word.

Reset
REQ-026 When rst_n = 0 at a clock edge: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0.
REQ-027 During reset in_ready SHALL be all 0; a word held mid-operation SHALL be discarded.
REQ-028 First transfer SHALL be possible on the first edge after rst_n returns to 1.

Structure
REQ-029 Package chan_mux_pkg SHALL hold the mode encoding constants MODE_MANUAL = 0, MODE_RR = 1.
REQ-030 The round-robin candidate search and ptr SHALL be one sub-module, rr_arbiter (parameter N; inputs req, advance; outputs grant index, grant_valid).
REQ-031 Output register and handshake logic SHALL remain in chan_mux_rr.

Verification (W=8, N=4)
REQ-032 Reset sequencing: with rst_n=0 and all in_valid=1, check out_valid=0, in_ready=0; release rst_n -> in_ready=0001 (RR, ptr 0).
REQ-033 MANUAL select: mode=0, sel=2, in_data ch2=8'hA5, in_valid=0100, out_ready=1 -> next cycle out_data=A5, out_ch=2; sel=3 with in_valid[3]=0 -> out_valid=0.
REQ-034 RR fairness: mode=1, in_valid=1111 constant, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 RR skip and wrap: ptr=3, in_valid=0010 -> grant ch1, ptr becomes 2; then in_valid=1001 -> grant ch3, ptr wraps to 0.
REQ-036 Backpressure: hold out_ready=0 with word 8'h3C on ch0 -> out_data stays 3C, in_ready=0000; raise out_ready with ch1 valid -> 3C drained, ch1 word loaded the same cycle.
REQ-037 Mid-stream reset: assert rst_n=0 while out_valid=1 -> next cycle out_valid=0, out_data=00, ptr=0, no held word emitted after reset.
